// File: rtl/div4s_seq.sv
// div4s_seq: sign-magnitude restoring divider, 8-bit dividend by 4-bit divisor, one quotient bit per cycle.
module div4s_seq (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] a_mag,
  input  logic       a_sign,
  input  logic [3:0] b_mag,
  input  logic       b_sign,
  output logic [7:0] q_mag,
  output logic       q_sign,
  output logic [3:0] r_mag,
  output logic       r_sign,
  output logic       busy,
  output logic       done,
  output logic       div0
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nx;
  logic [7:0] a_r, q_w, q_nx;
  logic [3:0] b_r;
  logic       as_r, bs_r, ge;
  logic [2:0] cnt;
  logic [4:0] pr, pr_sh, pr_nx;
  assign pr_sh = {pr[3:0], a_r[7]};
  assign ge    = pr_sh >= {1'b0, b_r};
  assign pr_nx = ge ? pr_sh - {1'b0, b_r} : pr_sh;
  assign q_nx  = {q_w[6:0], ge};
  always_comb begin
    state_nx = state;
    busy = state == RUN;
    done = state == DONE;
    if (state == IDLE && start) state_nx = b_mag == 4'd0 ? DONE : RUN;
    else if (state == RUN && cnt == 3'd0) state_nx = DONE;
    else if (state == DONE) state_nx = IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      a_r <= '0;
      q_w <= '0;
      b_r <= '0;
      as_r <= 1'b0;
      bs_r <= 1'b0;
      cnt <= '0;
      pr <= '0;
      q_mag <= '0;
      q_sign <= 1'b0;
      r_mag <= '0;
      r_sign <= 1'b0;
      div0 <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == IDLE && start) begin
        a_r <= a_mag;
        as_r <= a_sign;
        b_r <= b_mag;
        bs_r <= b_sign;
        cnt <= 3'd7;
        pr <= '0;
        q_w <= '0;
        if (b_mag == 4'd0) begin
          q_mag <= '0;
          q_sign <= 1'b0;
          r_mag <= '0;
          r_sign <= 1'b0;
          div0 <= 1'b1;
        end
      end else if (state == RUN) begin
        a_r <= {a_r[6:0], 1'b0};
        pr <= pr_nx;
        q_w <= q_nx;
        cnt <= cnt - 3'd1;
        if (cnt == 3'd0) begin
          q_mag <= q_nx;
          q_sign <= (as_r ^ bs_r) & (|q_nx);
          r_mag <= pr_nx[3:0];
          r_sign <= as_r & (|pr_nx[3:0]);
          div0 <= 1'b0;
        end
      end
    end
  end
endmodule

// File: doc/div4s_seq.md
DIV4S_SEQ -- requirements
Module: div4s_seq

Interface
REQ-001 clk  in  1  rising-edge clock for all state.
REQ-002 rst  in  1  synchronous reset, active-high.
REQ-003 start  in  1  request a division; sampled only in IDLE.
REQ-004 a_mag  in  8  dividend magnitude; matches the mult4s product magnitude z7..z0.
REQ-005 a_sign  in  1  dividend sign, 1 = negative; matches z8.
REQ-006 b_mag  in  4  divisor magnitude; matches x3..x0.
REQ-007 b_sign  in  1  divisor sign, 1 = negative; matches x4.
REQ-008 q_mag  out  8  quotient magnitude.
REQ-009 q_sign  out  1  quotient sign.
REQ-010 r_mag  out  4  remainder magnitude.
REQ-011 r_sign  out  1  remainder sign.
REQ-012 busy  out  1  high while a division is in progress.
REQ-013 done  out  1  one-cycle pulse: results valid.
REQ-014 div0  out  1  divide-by-zero flag for the last operation.

Function
REQ-015 The block SHALL implement a sign-magnitude, restoring, one-quotient-bit-per-cycle division with FSM states IDLE, RUN and DONE.

Operand capture and start
REQ-016 IDLE with start=1 at edge k SHALL latch a_mag, a_sign, b_mag and b_sign.
- Inputs are don't-care after edge k.
REQ-017 If b_mag != 0, edge k SHALL enter RUN with the step counter set to 7 and a 5-bit partial remainder cleared.
REQ-018 If b_mag == 0, edge k SHALL enter DONE directly, with q_mag=0, r_mag=0, q_sign=0, r_sign=0 and div0=1.

Iteration (RUN)
REQ-019 Each RUN edge SHALL perform one step:
- shift the partial remainder left, inserting the next dividend bit, MSB first;
- if the partial remainder >= b_mag, subtract b_mag and set the quotient bit to 1; otherwise set it to 0.
REQ-020 Edges k+1..k+8 SHALL perform the 8 steps.
- Edge k+8 SHALL load the outputs and enter DONE.
- done is high during the cycle after edge k+8, so latency is 9 edges.
REQ-021 q_sign SHALL be a_sign XOR b_sign, forced to 0 when q_mag == 0.
REQ-022 r_sign SHALL be a_sign, forced to 0 when r_mag == 0.
- No negative zero is ever produced.
REQ-023 r_mag SHALL be less than b_mag; the partial remainder never exceeds 5 bits.
REQ-024 div0 SHALL be 0 on every completion with a nonzero divisor.

Handshake
REQ-025 busy SHALL be 1 exactly while in RUN.
REQ-026 done SHALL be 1 exactly while in DONE; DONE always returns to IDLE on the next edge.
REQ-027 start SHALL be ignored in RUN and in DONE.
- A new operation requires start while in IDLE.
- Back-to-back operations therefore take 10 edges each.
REQ-028 q_mag, q_sign, r_mag, r_sign and div0 SHALL hold their values from DONE until the next completion or reset.
- Intermediate iteration values SHALL NOT appear on q_mag or r_mag.

Reset
REQ-029 rst=1 at any edge SHALL force IDLE and clear every output, counter and working register, including mid-RUN.
- The aborted operation SHALL produce no done pulse.
REQ-030 rst SHALL take priority over start on the same edge.
REQ-031 The first start sampled after rst deasserts SHALL be accepted normally.

Verification
REQ-032 The bench SHALL cover the following directed scenarios, checking busy, done timing, and that results hold after done:
- +55 / +5 -> q=+11, r=0, done 9 edges after start, busy high for 8 cycles.
- -55 / +5 -> q_sign=1, q_mag=11, r=0 with r_sign=0; +130 / -13 -> q_sign=1, q_mag=10, r=0.
- +100 / -7 -> q_sign=1, q_mag=14, r_sign=0, r_mag=2; -100 / -7 -> q_sign=0, q_mag=14, r_sign=1, r_mag=2.
- +255 / +1 -> q=255, r=0; -0 / -5 -> q_mag=0, q_sign=0, r=0, i.e. no negative zero.
- b_mag=0 with any dividend -> div0=1, q=0, r=0, done in the cycle after the start edge, busy never high.
- Start held high during RUN -> ignored; rst pulsed at step 4 -> all outputs 0, no done; a following +100 / -7 completes correctly.
